jk_seq_counter: RTL and testbench

JK_SEQ_COUNTER -- requirements
Module: jk_seq_counter

---
 rtl/jk_seq_counter_pkg.sv | 24 ++
 rtl/jk_seq_counter_cell.sv | 21 ++
 rtl/jk_seq_counter.sv | 91 +++++++++
 tb/tb_jk_seq_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_counter_pkg.sv
// rtl/jk_seq_counter_pkg.sv - shared constants and JK excitation helper for jk_seq_counter
package jk_seq_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  localparam logic [7:0] WRAP_CNT_MAX = 8'd255;

  // Excitation pairs are packed as {j, k}.
  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_RESET = 2'b01;

  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    if (cur == nxt) begin
      return JK_HOLD;
    end else if (nxt) begin
      return JK_SET;
    end else begin
      return JK_RESET;
    end
  endfunction

endpackage

// File: rtl/jk_seq_counter_cell.sv
// rtl/jk_seq_counter_cell.sv - single JK flip-flop (hold/set/reset/toggle)
module jk_cell
  import jk_seq_counter_pkg::*;
(
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);

  // No reset pin: the cell is cleared by driving K from the counter.
  always_ff @(posedge clk) begin
    case ({j, k})
      JK_HOLD:  q <= q;
      JK_SET:   q <= 1'b1;
      JK_RESET: q <= 1'b0;
      default:  q <= ~q;
    endcase
  end

endmodule

// File: rtl/jk_seq_counter.sv
// rtl/jk_seq_counter.sv - modulo up/down counter built from a JK flip-flop bank
module jk_seq_counter
  import jk_seq_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic [7:0]       wrap_cnt
);

  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             wrap;

  always_comb begin
    nxt  = q_bank;
    wrap = 1'b0;
    if (rst) begin
      nxt = '0;
    end else if (load) begin
      nxt = ({1'b0, din} < MOD_EXT) ? din : MAX_VAL;
    end else if (en) begin
      if (up) begin
        if (q_bank == MAX_VAL) begin
          nxt  = '0;
          wrap = 1'b1;
        end else begin
          nxt = q_bank + 1'b1;
        end
      end else begin
        if (q_bank == '0) begin
          nxt  = MAX_VAL;
          wrap = 1'b1;
        end else begin
          nxt = q_bank - 1'b1;
        end
      end
    end
  end

  always_comb begin
    cell_j = '0;
    cell_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {cell_j[i], cell_k[i]} = jk_excite(q_bank[i], nxt[i]);
    end
  end

  // During reset the cells still clear through K, but the visible excitation reads zero.
  assign j = rst ? '0 : cell_j;
  assign k = rst ? '0 : cell_k;
  assign q = q_bank;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_cell u_cell (
      .clk (clk),
      .j   (cell_j[g]),
      .k   (cell_k[g]),
      .q   (q_bank[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc       <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      tc <= wrap;
      if (wrap && (wrap_cnt != WRAP_CNT_MAX)) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jk_seq_counter.sv
// tb/tb_jk_seq_counter.sv - self-checking bench for jk_seq_counter (MODULUS 10 and 16)
module tb_jk_seq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;

  logic [3:0] q0, j0, k0, q1, j1, k1;
  logic       tc0, tc1;
  logic [7:0] wc0, wc1;

  int tests = 0;
  int fails = 0;

  int mq[2];
  int mtc[2];
  int mwc[2];
  int mm[2] = '{10, 16};
  bit started = 1'b0;

  always #5 clk = ~clk;

  jk_seq_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .j(j0), .k(k0), .tc(tc0), .wrap_cnt(wc0)
  );

  jk_seq_counter #(.WIDTH(4), .MODULUS(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q1), .j(j1), .k(k1), .tc(tc1), .wrap_cnt(wc1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mnext(input int cur, input int m, input bit ld, input int d,
                               input bit e, input bit u);
    if (ld) return (d < m) ? d : m - 1;
    if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        mq[n] = 0;
        mtc[n] = 0;
        mwc[n] = 0;
      end else begin
        automatic bit w = en && !load && (up ? (mq[n] == mm[n] - 1) : (mq[n] == 0));
        mq[n] = mnext(mq[n], mm[n], load, int'(din), en, up);
        mtc[n] = w ? 1 : 0;
        if (w && mwc[n] < 255) mwc[n]++;
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int n = 0; n < 2; n++) begin
        automatic int dq  = (n == 0) ? int'(q0) : int'(q1);
        automatic int dj  = (n == 0) ? int'(j0) : int'(j1);
        automatic int dk  = (n == 0) ? int'(k0) : int'(k1);
        automatic int dtc = (n == 0) ? int'(tc0) : int'(tc1);
        automatic int dwc = (n == 0) ? int'(wc0) : int'(wc1);
        automatic int nx  = mnext(mq[n], mm[n], load, int'(din), en, up);
        automatic int ej  = rst ? 0 : (nx & ~mq[n] & 15);
        automatic int ek  = rst ? 0 : (mq[n] & ~nx & 15);
        check($sformatf("model q[%0d]", n), dq, mq[n]);
        check($sformatf("model tc[%0d]", n), dtc, mtc[n]);
        check($sformatf("model wrap_cnt[%0d]", n), dwc, mwc[n]);
        check($sformatf("model j[%0d]", n), dj, ej);
        check($sformatf("model k[%0d]", n), dk, ek);
        check($sformatf("j&k[%0d]", n), dj & dk, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    rst = 1'b1;
    tick();
    check("reset q", int'(q0), 0);
    check("reset tc", int'(tc0), 0);
    check("reset wrap_cnt", int'(wc0), 0);
    check("reset j", int'(j0), 0);
    check("reset k", int'(k0), 0);
    rst = 1'b0;

    // Up-count through one wrap.
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("up q step %0d", i), int'(q0), up_exp[i]);
      check($sformatf("up tc step %0d", i), int'(tc0), (i == 9) ? 1 : 0);
    end
    check("up wrap_cnt", int'(wc0), 1);

    // Down-count wrap from 0.
    en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    up = 1'b0;
    #1;
    check("down j", int'(j0), 9);
    check("down k", int'(k0), 0);
    tick();
    check("down q", int'(q0), 9);
    check("down tc", int'(tc0), 1);
    check("down wrap_cnt", int'(wc0), 1);
    en = 1'b0;

    // Loads, including clamp and loading the wrap value.
    load = 1'b1;
    din = 4'd7;
    tick();
    check("load7 q", int'(q0), 7);
    check("load7 tc", int'(tc0), 0);
    din = 4'd13;
    #1;
    check("load13 j", int'(j0), 8);
    check("load13 k", int'(k0), 6);
    tick();
    check("load13 q clamp", int'(q0), 9);
    check("load13 tc", int'(tc0), 0);
    din = 4'd0;
    tick();
    check("load0 q", int'(q0), 0);
    check("load0 tc", int'(tc0), 0);

    // Reset beats load and count in the same cycle.
    din = 4'd5;
    tick();
    check("load5 q", int'(q0), 5);
    rst = 1'b1;
    en = 1'b1;
    din = 4'd3;
    #1;
    check("rst j out", int'(j0), 0);
    check("rst k out", int'(k0), 0);
    check("rst cell j", int'(dut0.cell_j), 0);
    check("rst cell k", int'(dut0.cell_k), 5);
    tick();
    check("rst q", int'(q0), 0);
    check("rst tc", int'(tc0), 0);
    check("rst wrap_cnt", int'(wc0), 0);

    // Reset coinciding with a would-be down wrap leaves no tc pulse.
    load = 1'b0;
    up = 1'b0;
    tick();
    check("rst wrap q", int'(q0), 0);
    check("rst wrap tc", int'(tc0), 0);
    rst = 1'b0;
    en = 1'b0;

    // Hold with random up/din.
    load = 1'b1;
    din = 4'd6;
    tick();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      up = 1'($urandom);
      din = 4'($urandom);
      tick();
      check($sformatf("hold q %0d", i), int'(q0), 6);
      check($sformatf("hold tc %0d", i), int'(tc0), 0);
    end

    // Long up-count: 300 wraps at MODULUS 16, saturating wrap_cnt.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    up = 1'b1;
    repeat (4800) tick();
    check("sat wrap_cnt m16", int'(wc1), 255);
    check("sat q m16", int'(q1), 0);
    check("sat wrap_cnt m10", int'(wc0), 255);
    check("sat q m10", int'(q0), 0);
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
